// File: rtl/uart_burst_loopback_if.sv
// Handshake bundle for uart_burst_loopback: UART tx/rx strobes, readback stream and status.
// master is the burst engine's view; slave is the surrounding UART/consumer view.
interface uart_burst_loopback_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              start;
   logic              tx_en;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;
   logic              rx_done;
   logic [DATA_W-1:0] rx_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [15:0]       err_cnt;

   modport master (
      input  start, tx_busy, rx_done, rx_data, rd_ready,
      output tx_en, tx_data, rd_valid, rd_data, busy, done, ovf, err_cnt
   );

   modport slave (
      output start, tx_busy, rx_done, rx_data, rd_ready,
      input  tx_en, tx_data, rd_valid, rd_data, busy, done, ovf, err_cnt
   );
endinterface

// File: rtl/uart_burst_loopback.sv
// Sends a pattern burst through a UART, buffers the looped-back words and streams them out.
// Define UART_BURST_CHECK_EN to compile the readback checker that drives err_cnt.
module uart_burst_loopback #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned BURST_LEN  = 256,
   parameter int unsigned FIFO_DEPTH = 256,
   parameter int unsigned PAT_START  = 0,
   parameter int unsigned PAT_STEP   = 1
) (
   input logic                   sys_clk,
   input logic                   sys_rst_n,
   uart_burst_loopback_if.master bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [DATA_W-1:0] START_W  = DATA_W'(PAT_START);
   localparam logic [DATA_W-1:0] STEP_W   = DATA_W'(PAT_STEP);
   localparam logic [CW-1:0]     LAST_CNT = CW'(BURST_LEN);

   typedef enum logic [2:0] {
      StIdle, StLoad, StSend, StWaitBusy, StWaitFree, StWaitRx, StDrain, StFin
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     tx_cnt_q, rx_cnt_q, rd_cnt_q;
   logic [CW-1:0]     rx_cnt_d, rd_cnt_d;
   logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] pattern_q, tx_data_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic              ovf_q;
   logic              fifo_full, fifo_empty, wr_en, rd_en, tx_step, tx_last, burst_go;
   logic [DATA_W-1:0] fifo_head;

   // Extra pointer MSB separates full from empty when the low bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

   assign burst_go = (state_q == StIdle) && bus.start;
   assign wr_en    = bus.rx_done && (state_q != StIdle) && (state_q != StFin) &&
                     (rx_cnt_q < LAST_CNT) && !fifo_full;
   assign rd_en    = (state_q == StDrain) && !fifo_empty && bus.rd_ready;
   assign tx_step  = (state_q == StWaitFree) && !bus.tx_busy;
   assign tx_last  = (tx_cnt_q + CW'(1)) >= LAST_CNT;
   assign rx_cnt_d = rx_cnt_q + CW'(wr_en);
   assign rd_cnt_d = rd_cnt_q + CW'(rd_en);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (bus.start) state_d = StLoad;
         StLoad:     state_d = StSend;
         StSend:     state_d = StWaitBusy;
         StWaitBusy: if (bus.tx_busy) state_d = StWaitFree;
         StWaitFree: if (!bus.tx_busy) state_d = tx_last ? StWaitRx : StLoad;
         StWaitRx:   if (rx_cnt_d == LAST_CNT) state_d = StDrain;
         StDrain:    if (rd_cnt_d == LAST_CNT) state_d = StFin;
         StFin:      state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.tx_en    = 1'b0;
      bus.rd_valid = 1'b0;
      bus.busy     = 1'b1;
      bus.done     = 1'b0;
      case (state_q)
         StIdle:  bus.busy     = 1'b0;
         StSend:  bus.tx_en    = 1'b1;
         StDrain: bus.rd_valid = !fifo_empty;
         StFin:   bus.done     = 1'b1;
         default: ;
      endcase
   end

   assign bus.rd_data = bus.rd_valid ? fifo_head : '0;
   assign bus.tx_data = tx_data_q;
   assign bus.ovf     = ovf_q;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pattern_q <= START_W;
         tx_data_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (burst_go) begin
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pattern_q <= START_W;
            ovf_q     <= 1'b0;
         end else begin
            if (state_q == StLoad) tx_data_q <= pattern_q;
            if (tx_step) begin
               tx_cnt_q  <= tx_cnt_q + CW'(1);
               pattern_q <= pattern_q + STEP_W;
            end
            rx_cnt_q <= rx_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + CW'(1);
         end
         // A word that could not be stored marks the burst, even on the start cycle.
         if (bus.rx_done && !wr_en) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst_n && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
   end

`ifdef UART_BURST_CHECK_EN
   logic [DATA_W-1:0] expected_q;
   logic [15:0]       err_cnt_q;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         expected_q <= START_W;
         err_cnt_q  <= '0;
      end else if (burst_go) begin
         expected_q <= START_W;
         err_cnt_q  <= '0;
      end else begin
         if (state_q == StWaitRx && state_d == StDrain) expected_q <= START_W;
         if (rd_en) begin
            expected_q <= expected_q + STEP_W;
            if (fifo_head != expected_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_uart_burst_loopback.sv
// Directed bench: a loopback UART model feeds two engines (default and wrapped pattern).
module tb_uart_burst_loopback;
`ifdef UART_BURST_CHECK_EN
   localparam int CORRUPT_ERRS = 1;
`else
   localparam int CORRUPT_ERRS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       tx_busy, rx_done;
   logic [7:0] rx_data;
   logic       rd_ready = 1'b0;
   logic       sel_b = 1'b0;
   int         rst_gen = 0, tx_base = 0, burst_len_cur = 256, corrupt_idx = -1, extra_rx = 0;
   logic [7:0] tx_log[$];
   logic [7:0] rd_log[$];
   int         done_cnt = 0;
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   uart_burst_loopback_if #(.DATA_W(8)) a_if ();
   uart_burst_loopback_if #(.DATA_W(8)) b_if ();

   assign a_if.start = start_a;
   assign b_if.start = start_b;
   assign a_if.tx_busy = tx_busy;
   assign b_if.tx_busy = tx_busy;
   assign a_if.rx_done = rx_done;
   assign b_if.rx_done = rx_done;
   assign a_if.rx_data = rx_data;
   assign b_if.rx_data = rx_data;
   assign a_if.rd_ready = rd_ready;
   assign b_if.rd_ready = rd_ready;

   uart_burst_loopback #(.DATA_W(8)) dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(a_if.master)
   );

   uart_burst_loopback #(
      .DATA_W(8), .BURST_LEN(100), .FIFO_DEPTH(128), .PAT_START(32'hF0), .PAT_STEP(3)
   ) dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(b_if.master)
   );

   // UART loopback model: busy rises 2 cycles after tx_en, lasts 10 cycles, then echoes the word.
   initial begin : uart_model
      int         rel, gen;
      logic [7:0] w;
      tx_busy = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      forever begin
         @(negedge clk);
         if (sel_b ? b_if.tx_en : a_if.tx_en) begin
            w   = sel_b ? b_if.tx_data : a_if.tx_data;
            rel = tx_log.size() - tx_base;
            gen = rst_gen;
            tx_log.push_back(w);
            repeat (2) @(negedge clk);
            tx_busy = 1'b1;
            repeat (10) @(negedge clk);
            tx_busy = 1'b0;
            if (gen == rst_gen) begin
               rx_done = 1'b1;
               rx_data = (rel == corrupt_idx) ? 8'hAA : w;
            end
            @(negedge clk);
            rx_done = 1'b0;
            if (gen == rst_gen && rel == burst_len_cur - 1) begin
               repeat (extra_rx) begin
                  @(negedge clk);
                  rx_done = 1'b1;
                  @(negedge clk);
                  rx_done = 1'b0;
               end
            end
         end
      end
   end

   initial begin : rd_monitor
      forever begin
         @(negedge clk);
         if (sel_b ? b_if.rd_valid && rd_ready : a_if.rd_valid && rd_ready)
            rd_log.push_back(sel_b ? b_if.rd_data : a_if.rd_data);
         if (sel_b ? b_if.done : a_if.done) done_cnt++;
      end
   end

   task automatic pulse_start(input logic use_b);
      @(negedge clk);
      if (use_b) start_b = 1'b1;
      else       start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int bound, input logic toggle, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < bound && !ok; c++) begin
         @(posedge clk);
         #1;
         if (toggle) rd_ready = !rd_ready;
         @(negedge clk);
         if (sel_b ? b_if.done : a_if.done) ok = 1'b1;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 8;
      if (a_if.tx_en !== 1'b0) begin errors++; $display("FAIL rst_tx_en got %b want 0", a_if.tx_en); end
      if (a_if.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", a_if.tx_data); end
      if (a_if.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", a_if.rd_valid); end
      if (a_if.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", a_if.rd_data); end
      if (a_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_if.busy); end
      if (a_if.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", a_if.done); end
      if (a_if.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", a_if.ovf); end
      if (a_if.err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err got %h want 0", a_if.err_cnt); end
      checks++;
      if ({b_if.tx_en, b_if.rd_valid, b_if.busy, b_if.done, b_if.ovf} !== 5'b0) begin
         errors++; $display("FAIL rst_b_flags got %b want 00000",
                            {b_if.tx_en, b_if.rd_valid, b_if.busy, b_if.done, b_if.ovf});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Runs one burst on the selected engine and checks tx words, readback words and status.
   task automatic run_burst(input logic use_b, input int len, input int start_v, input int step,
                            input logic toggle, input logic exp_ovf, input int exp_err);
      int         tb0, rb0, d0;
      logic       ok;
      logic [7:0] e;
      sel_b = use_b;
      burst_len_cur = len;
      tx_base = tx_log.size();
      rb0 = rd_log.size();
      tb0 = tx_base;
      d0 = done_cnt;
      rd_ready = 1'b1;
      pulse_start(use_b);
      wait_done(20000, toggle, ok);
      rd_ready = 1'b1;
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL done_timeout got %b want 1", ok); end
      checks += 3;
      if (tx_log.size() - tb0 != len) begin
         errors++; $display("FAIL tx_count got %0d want %0d", tx_log.size() - tb0, len);
      end
      if (rd_log.size() - rb0 != len) begin
         errors++; $display("FAIL rd_count got %0d want %0d", rd_log.size() - rb0, len);
      end
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL done_pulses got %0d want 1", done_cnt - d0);
      end
      for (int i = 0; i < len; i++) begin
         e = 8'(start_v + step * i);
         checks++;
         if (tx_log[tb0 + i] !== e) begin
            errors++; $display("FAIL tx_word[%0d] got %h want %h", i, tx_log[tb0 + i], e);
         end
         if (i == corrupt_idx) e = 8'hAA;
         checks++;
         if (rd_log[rb0 + i] !== e) begin
            errors++; $display("FAIL rd_word[%0d] got %h want %h", i, rd_log[rb0 + i], e);
         end
      end
      checks += 3;
      if ((use_b ? b_if.ovf : a_if.ovf) !== exp_ovf) begin
         errors++; $display("FAIL ovf got %b want %b", use_b ? b_if.ovf : a_if.ovf, exp_ovf);
      end
      if ((use_b ? b_if.err_cnt : a_if.err_cnt) !== 16'(exp_err)) begin
         errors++; $display("FAIL err_cnt got %0d want %0d",
                            use_b ? b_if.err_cnt : a_if.err_cnt, exp_err);
      end
      if ((use_b ? b_if.busy : a_if.busy) !== 1'b0) begin
         errors++; $display("FAIL busy_after got %b want 0", use_b ? b_if.busy : a_if.busy);
      end
   endtask

   task automatic test_default_burst();
      corrupt_idx = -1;
      extra_rx = 0;
      run_burst(1'b0, 256, 0, 1, 1'b0, 1'b0, 0);
   endtask

   task automatic test_wrap_pattern();
      corrupt_idx = -1;
      extra_rx = 0;
      run_burst(1'b1, 100, 'hF0, 3, 1'b0, 1'b0, 0);
      checks++;
      if (tx_log[tx_base + 6] !== 8'h02) begin
         errors++; $display("FAIL wrap_word6 got %h want 02", tx_log[tx_base + 6]);
      end
   endtask

   task automatic test_corrupt();
      corrupt_idx = 5;
      extra_rx = 0;
      run_burst(1'b1, 100, 'hF0, 3, 1'b0, 1'b0, CORRUPT_ERRS);
      corrupt_idx = -1;
   endtask

   task automatic test_ovf_toggle();
      corrupt_idx = -1;
      extra_rx = 3;
      run_burst(1'b0, 256, 0, 1, 1'b1, 1'b1, 0);
      extra_rx = 0;
   endtask

   task automatic test_reset_mid_send();
      logic found;
      sel_b = 1'b0;
      burst_len_cur = 256;
      tx_base = tx_log.size();
      rd_ready = 1'b1;
      found = 1'b0;
      pulse_start(1'b0);
      for (int c = 0; c < 5000 && !found; c++) begin
         @(negedge clk);
         if (a_if.tx_en && a_if.tx_data == 8'd40) found = 1'b1;
      end
      checks++;
      if (found !== 1'b1) begin errors++; $display("FAIL word40_seen got %b want 1", found); end
      rst_n = 1'b0;
      @(negedge clk);
      checks += 5;
      if (a_if.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", a_if.busy); end
      if (a_if.tx_en !== 1'b0) begin errors++; $display("FAIL mid_tx_en got %b want 0", a_if.tx_en); end
      if (a_if.tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got %h want 00", a_if.tx_data); end
      if ({a_if.rd_valid, a_if.done, a_if.ovf} !== 3'b0) begin
         errors++; $display("FAIL mid_flags got %b want 000", {a_if.rd_valid, a_if.done, a_if.ovf});
      end
      if (a_if.rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data got %h want 00", a_if.rd_data); end
      rst_gen++;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (a_if.busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst got %b want 0", a_if.busy); end
      run_burst(1'b0, 256, 0, 1, 1'b0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_default_burst();
      test_wrap_pattern();
      test_corrupt();
      test_ovf_toggle();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_burst_loopback.md
UART_BURST_LOOPBACK -- requirements
Module: uart_burst_loopback

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of tx/rx/readback data.
REQ-002 SHALL have parameter BURST_LEN, default 256: words per burst, range 1..FIFO_DEPTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 256: receive buffer depth, power of 2.
REQ-004 SHALL have parameter PAT_START, default 0: first pattern word.
REQ-005 SHALL have parameter PAT_STEP, default 1: pattern increment per word, modulo 2^DATA_W.
REQ-006 SHALL have port sys_clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port start, input, 1: one-cycle burst request.
REQ-009 SHALL have port tx_en, output, 1: one-cycle send pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, DATA_W: word to send.
REQ-011 SHALL have port tx_busy, input, 1: transmitter busy.
REQ-012 SHALL have port rx_done, input, 1: one-cycle received-word strobe.
REQ-013 SHALL have port rx_data, input, DATA_W: received word, valid with rx_done.
REQ-014 SHALL have port rd_valid, output, 1: readback word available.
REQ-015 SHALL have port rd_ready, input, 1: readback consumer ready.
REQ-016 SHALL have port rd_data, output, DATA_W: readback word.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at end of readback.
REQ-019 SHALL have port ovf, output, 1: sticky drop flag.
REQ-020 SHALL have port err_cnt, output, 16: saturating mismatch count.

Function
REQ-021 SHALL implement states IDLE, LOAD, SEND, WAIT_BUSY, WAIT_FREE, WAIT_RX, DRAIN, FIN.
- IDLE: start=1 -> LOAD; clears tx/rx/rd counters, err_cnt, ovf; pattern := PAT_START.
- start outside IDLE: ignored.
REQ-022 SHALL, in LOAD, register tx_data := pattern, then go to SEND.
REQ-023 SHALL, in SEND, assert tx_en for exactly one cycle, then go to WAIT_BUSY.
- tx_data SHALL stay stable from LOAD until the next LOAD.
REQ-024 SHALL leave WAIT_BUSY only when tx_busy=1, tolerating any rise latency.
REQ-025 SHALL leave WAIT_FREE when tx_busy=0.
- Then tx_cnt+1 and pattern += PAT_STEP (wraps mod 2^DATA_W).
- tx_cnt+1 < BURST_LEN -> LOAD; otherwise -> WAIT_RX.
REQ-026 SHALL write rx_data to the FIFO on rx_done when not IDLE/FIN, rx_cnt < BURST_LEN and FIFO not full; rx_cnt+1.
- Otherwise the word is dropped and ovf := 1.
REQ-027 SHALL, in WAIT_RX, go to DRAIN once rx_cnt == BURST_LEN; expected := PAT_START.
- The same cycle's write counts.
REQ-028 SHALL, in DRAIN, drive rd_valid = !fifo_empty with rd_data = FIFO head (first-word-fall-through).
- Pop on rd_valid & rd_ready; rd_data holds while rd_ready=0.
REQ-029 SHALL, per pop, add 1 to rd_cnt and step expected by PAT_STEP.
- After the last pop (rd_cnt == BURST_LEN) -> FIN.
REQ-030 SHALL, in FIN, pulse done for one cycle, then go to IDLE.
- err_cnt and ovf SHALL hold until the next start.
REQ-031 SHALL give FIFO pointers log2(FIFO_DEPTH)+1 bits.
- Full/empty from MSB compare; wrap-around is transparent.
REQ-032 SHALL keep tx_en=0 and rd_valid=0 outside SEND and DRAIN respectively.

Reset
REQ-033 SHALL, while sys_rst_n=0 at a clock edge, go to IDLE, empty the FIFO and reset all counters.
- Outputs: tx_en=0, tx_data=0, rd_valid=0, rd_data=0, busy=0, done=0, ovf=0, err_cnt=0.
REQ-034 SHALL abort any burst in progress on reset and need a new start afterwards.

Configuration
REQ-035 SHALL compile the readback checker only when UART_BURST_CHECK_EN is defined.
- Defined: on each pop, rd_data != expected -> err_cnt+1, saturating at 16'hFFFF.
- Undefined: checker and expected register are absent; err_cnt is held at 0; all other behaviour is identical.

Verification
REQ-036 SHALL cover: defaults, tx_busy 2 cycles after tx_en for 10 cycles, rx loopback, rd_ready=1 -> 256 tx_en pulses with tx_data 0x00..0xFF, rd_data 0x00..0xFF, done once, err_cnt=0, ovf=0.
REQ-037 SHALL cover: PAT_START=8'hF0, PAT_STEP=3, BURST_LEN=100 -> word 6 = 8'h02 (wrap), 100 words read back, err_cnt=0.
REQ-038 SHALL cover: CHECK_EN defined, rx word 5 corrupted to 8'hAA -> err_cnt=1 at done; CHECK_EN undefined -> err_cnt=0.
REQ-039 SHALL cover: 3 extra rx_done after 256 words -> ovf=1, exactly 256 words read.
- rd_ready toggling 1/0 every cycle -> no loss or duplication, order kept.
REQ-040 SHALL cover: sys_rst_n low for 1 cycle mid-SEND at word 40 -> next cycle outputs at reset values, busy=0.
- A new start restarts at PAT_START with FIFO empty.
